// File: rtl/gtx_rx_align.sv
// gtx_rx_align: receive-side comma aligner for the 1000BASE-X serdes path.
// Searches a 20-bit window of the raw serdes words for a 7-bit comma at
// any of 10 bit offsets. It confirms the offset over several commas,
// locks onto it, and then emits bit-aligned 10-bit symbols for the
// 8b/10b decoder. All logic runs in the gmii_rx_clk domain.
// Optional build macro: RX_ALIGN_STATS_EN adds the realign_cnt and
// lockloss_cnt saturating statistics counters.
//
// Legal parameter ranges: CONFIRM 2..15, CHECK_TIMEOUT 2..255,
// LOS_ERRS 1..15.

module gtx_rx_align #(
  parameter int CONFIRM       = 3,
  parameter int CHECK_TIMEOUT = 64,
  parameter int LOS_ERRS      = 4
) (
  input  logic        gmii_rx_clk,
  input  logic        rst,
  input  logic [9:0]  rxd_in,
  input  logic        resync,
  output logic [9:0]  rxd_out,
  output logic        comma_out,
  output logic        rx_locked,
  output logic [3:0]  offset_mon
`ifdef RX_ALIGN_STATS_EN
  ,
  output logic [15:0] realign_cnt,
  output logic [15:0] lockloss_cnt
`endif
);

  localparam logic [3:0] CONFIRM_L  = 4'(CONFIRM);
  localparam logic [7:0] TIMEOUT_L  = 8'(CHECK_TIMEOUT);
  localparam logic [3:0] LOS_ERRS_L = 4'(LOS_ERRS);

  typedef enum logic [1:0] {
    HUNT   = 2'd0,
    CHECK  = 2'd1,
    LOCKED = 2'd2
  } state_t;

  // Registered state
  logic [9:0] prev_q;
  state_t     state_q,     state_d;
  logic [3:0] off_q,       off_d;
  logic [3:0] cnt_q,       cnt_d;
  logic [7:0] to_q,        to_d;
  logic [3:0] err_q,       err_d;
  logic [9:0] rxd_out_q,   rxd_out_d;
  logic       comma_out_q, comma_out_d;
  logic       rx_locked_q, rx_locked_d;

  // Window and detection results
  logic [19:1] win;
  logic [9:0]  comma_vec;
  logic        any_comma;
  logic [3:0]  kmin;
  logic [9:0]  cand_sym;
  logic        comma_at_off;
  logic [3:0]  cnt_inc;
  logic [7:0]  to_inc;
  logic [3:0]  err_inc;

  // Window bit 0 (rxd_in[0]) would only be needed for offset 10, which is
  // offset 0 of the next cycle, so it is left out and the numbering kept.
  assign win = {prev_q, rxd_in[9:1]};

  assign cnt_inc = cnt_q + 4'd1;
  assign to_inc  = to_q + 8'd1;
  assign err_inc = err_q + 4'd1;

  // Comma detection at all 10 offsets in parallel
  always_comb begin
    // NOTE: every variable written in a combinational block gets a default
    // first, so no path leaves it holding its old value (an inferred latch).
    comma_vec = '0;
    for (int k = 0; k < 10; k++) begin
      comma_vec[k] = (win[19-k -: 7] == 7'b0011111) ||
                     (win[19-k -: 7] == 7'b1100000);
    end
  end

  assign any_comma = |comma_vec;

  // Lowest matching offset wins: scan downward so the last hit is the lowest k
  always_comb begin
    kmin = 4'd0;
    for (int k = 9; k >= 0; k--) begin
      if (comma_vec[k]) kmin = 4'(k);
    end
  end

  // Select the symbol and comma flag at the current offset
  always_comb begin
    cand_sym     = '0;
    comma_at_off = 1'b0;
    for (int k = 0; k < 10; k++) begin
      if (off_q == 4'(k)) begin
        cand_sym     = win[19-k -: 10];
        comma_at_off = comma_vec[k];
      end
    end
  end

  // Alignment state machine next-state and counter logic
  always_comb begin
    state_d = state_q;
    off_d   = off_q;
    cnt_d   = cnt_q;
    to_d    = to_q;
    err_d   = err_q;

    if (resync) begin
      // A comma arriving with resync is deliberately ignored.
      state_d = HUNT;
      cnt_d   = '0;
      to_d    = '0;
      err_d   = '0;
    end else begin
      unique case (state_q)
        HUNT: begin
          if (any_comma) begin
            off_d   = kmin;
            cnt_d   = 4'd1;
            to_d    = '0;
            err_d   = '0;
            state_d = CHECK;
          end
        end

        CHECK: begin
          if (comma_at_off) begin
            cnt_d = cnt_inc;
            to_d  = '0;
            if (cnt_inc == CONFIRM_L) begin
              state_d = LOCKED;
              err_d   = '0;
            end
          end else if (any_comma) begin
            // Comma seen elsewhere: restart confirmation at the new offset.
            off_d = kmin;
            cnt_d = 4'd1;
            to_d  = '0;
          end else if (to_inc == TIMEOUT_L) begin
            state_d = HUNT;
            cnt_d   = '0;
            to_d    = '0;
          end else begin
            to_d = to_inc;
          end
        end

        LOCKED: begin
          // Comma-free cycles change nothing: jumbo frames have no commas.
          if (comma_at_off) begin
            err_d = '0;
          end else if (any_comma) begin
            if (err_inc == LOS_ERRS_L) begin
              state_d = HUNT;
              err_d   = '0;
              cnt_d   = '0;
              to_d    = '0;
            end else begin
              err_d = err_inc;
            end
          end
        end

        default: begin
          state_d = HUNT;
          cnt_d   = '0;
          to_d    = '0;
          err_d   = '0;
        end
      endcase
    end
  end

  // Datapath outputs follow off_q every cycle; consumers qualify with rx_locked
  assign rxd_out_d   = cand_sym;
  assign comma_out_d = comma_at_off;
  assign rx_locked_d = (state_d == LOCKED);

  // State, counters and registered outputs, with synchronous reset
  always_ff @(posedge gmii_rx_clk) begin
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples the pre-edge values, independent of statement order.
    if (rst) begin
      prev_q      <= '0;
      state_q     <= HUNT;
      off_q       <= '0;
      cnt_q       <= '0;
      to_q        <= '0;
      err_q       <= '0;
      rxd_out_q   <= '0;
      comma_out_q <= 1'b0;
      rx_locked_q <= 1'b0;
    end else begin
      prev_q      <= rxd_in;
      state_q     <= state_d;
      off_q       <= off_d;
      cnt_q       <= cnt_d;
      to_q        <= to_d;
      err_q       <= err_d;
      rxd_out_q   <= rxd_out_d;
      comma_out_q <= comma_out_d;
      rx_locked_q <= rx_locked_d;
    end
  end

  assign rxd_out    = rxd_out_q;
  assign comma_out  = comma_out_q;
  assign rx_locked  = rx_locked_q;
  assign offset_mon = off_q;

`ifdef RX_ALIGN_STATS_EN
  logic        realign_evt;
  logic        lockloss_evt;
  logic [15:0] realign_q,  realign_d;
  logic [15:0] lockloss_q, lockloss_d;

  // Event decode and saturating increments for the statistics counters
  always_comb begin
    realign_evt  = !resync && any_comma &&
                   ((state_q == HUNT) || ((state_q == CHECK) && !comma_at_off));
    lockloss_evt = (state_q == LOCKED) && (state_d == HUNT);
    realign_d    = realign_q;
    lockloss_d   = lockloss_q;
    if (realign_evt && (realign_q != 16'hFFFF))   realign_d  = realign_q + 16'd1;
    if (lockloss_evt && (lockloss_q != 16'hFFFF)) lockloss_d = lockloss_q + 16'd1;
  end

  // Statistics registers, cleared only by reset
  always_ff @(posedge gmii_rx_clk) begin
    if (rst) begin
      realign_q  <= '0;
      lockloss_q <= '0;
    end else begin
      realign_q  <= realign_d;
      lockloss_q <= lockloss_d;
    end
  end

  assign realign_cnt  = realign_q;
  assign lockloss_cnt = lockloss_q;
`endif

endmodule

// File: tb/tb_gtx_rx_align.sv
// tb_gtx_rx_align: directed, self-checking bench for gtx_rx_align.
// A table of single-cycle vectors covers reset, aligned lock and resync;
// hand-written bit-stream sequences cover offsets, loss of lock, the
// CHECK timeout boundary, long comma-free frames and mid-run reset.

module tb_gtx_rx_align;

  logic        gmii_rx_clk = 1'b0;
  logic        rst = 1'b1;
  logic [9:0]  rxd_in = '0;
  logic        resync = 1'b0;
  logic [9:0]  rxd_out;
  logic        comma_out;
  logic        rx_locked;
  logic [3:0]  offset_mon;
`ifdef RX_ALIGN_STATS_EN
  logic [15:0] realign_cnt;
  logic [15:0] lockloss_cnt;
`endif

  gtx_rx_align dut (
    .gmii_rx_clk (gmii_rx_clk),
    .rst         (rst),
    .rxd_in      (rxd_in),
    .resync      (resync),
    .rxd_out     (rxd_out),
    .comma_out   (comma_out),
    .rx_locked   (rx_locked),
    .offset_mon  (offset_mon)
`ifdef RX_ALIGN_STATS_EN
    ,
    .realign_cnt (realign_cnt),
    .lockloss_cnt(lockloss_cnt)
`endif
  );

  always #5 gmii_rx_clk = ~gmii_rx_clk;

  int total = 0;
  int bad   = 0;
  bit bq[$];

  localparam logic [9:0]  K_SYM = 10'h0FA;
  localparam logic [9:0]  D_SYM = 10'h245;
  localparam logic [9:0]  FILL  = 10'h2AA;

  typedef struct {
    logic [9:0] rxd;
    logic       rs;
    logic [9:0] e_rxd;
    logic       e_comma;
    logic       e_locked;
    logic [3:0] e_off;
  } vec_t;

  vec_t vecs[16];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Drive one word, let the DUT clock it, then settle just after the edge.
  task automatic step(input logic [9:0] w, input logic rs);
    rxd_in = w;
    resync = rs;
    @(posedge gmii_rx_clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    step('0, 1'b0);
    step('0, 1'b0);
    rst = 1'b0;
    bq.delete();
  endtask

  task automatic q_push(input logic [19:0] v, input int n);
    for (int i = n - 1; i >= 0; i--) bq.push_back(v[i]);
  endtask

  task automatic push_i2(input int n);
    logic [19:0] p;
    p = {K_SYM, D_SYM};
    repeat (n) q_push(p, 20);
  endtask

  // Take the next 10 bits of the stream (earliest bit into bit 9) and step.
  task automatic step_q(input logic rs);
    logic [9:0] w;
    for (int i = 9; i >= 0; i--) w[i] = (bq.size() > 0) ? bq.pop_front() : 1'b0;
    step(w, rs);
  endtask

  initial begin
    int unlocked;
    int locked_seen;

    // Aligned /I2/ from reset, then resync together with an aligned comma.
    vecs[0]  = '{K_SYM, 1'b0, 10'h000, 1'b0, 1'b0, 4'd0};
    vecs[1]  = '{D_SYM, 1'b0, K_SYM,   1'b1, 1'b0, 4'd0};
    vecs[2]  = '{K_SYM, 1'b0, D_SYM,   1'b0, 1'b0, 4'd0};
    vecs[3]  = '{D_SYM, 1'b0, K_SYM,   1'b1, 1'b0, 4'd0};
    vecs[4]  = '{K_SYM, 1'b0, D_SYM,   1'b0, 1'b0, 4'd0};
    vecs[5]  = '{D_SYM, 1'b0, K_SYM,   1'b1, 1'b1, 4'd0};
    vecs[6]  = '{K_SYM, 1'b0, D_SYM,   1'b0, 1'b1, 4'd0};
    vecs[7]  = '{D_SYM, 1'b0, K_SYM,   1'b1, 1'b1, 4'd0};
    vecs[8]  = '{K_SYM, 1'b0, D_SYM,   1'b0, 1'b1, 4'd0};
    vecs[9]  = '{D_SYM, 1'b1, K_SYM,   1'b1, 1'b0, 4'd0};
    vecs[10] = '{K_SYM, 1'b0, D_SYM,   1'b0, 1'b0, 4'd0};
    vecs[11] = '{D_SYM, 1'b0, K_SYM,   1'b1, 1'b0, 4'd0};
    vecs[12] = '{K_SYM, 1'b0, D_SYM,   1'b0, 1'b0, 4'd0};
    vecs[13] = '{D_SYM, 1'b0, K_SYM,   1'b1, 1'b0, 4'd0};
    vecs[14] = '{K_SYM, 1'b0, D_SYM,   1'b0, 1'b0, 4'd0};
    vecs[15] = '{D_SYM, 1'b0, K_SYM,   1'b1, 1'b1, 4'd0};

    do_reset();
    check("reset_rxd_out",   32'(rxd_out),    32'h0);
    check("reset_comma_out", 32'(comma_out),  32'h0);
    check("reset_locked",    32'(rx_locked),  32'h0);
    check("reset_offset",    32'(offset_mon), 32'h0);
`ifdef RX_ALIGN_STATS_EN
    check("reset_realign",   32'(realign_cnt),  32'h0);
    check("reset_lockloss",  32'(lockloss_cnt), 32'h0);
`endif

    for (int i = 0; i < 16; i++) begin
      step(vecs[i].rxd, vecs[i].rs);
      check($sformatf("vec%0d_rxd_out", i),   32'(rxd_out),    32'(vecs[i].e_rxd));
      check($sformatf("vec%0d_comma_out", i), 32'(comma_out),  32'(vecs[i].e_comma));
      check($sformatf("vec%0d_locked", i),    32'(rx_locked),  32'(vecs[i].e_locked));
      check($sformatf("vec%0d_offset", i),    32'(offset_mon), 32'(vecs[i].e_off));
    end
    step(K_SYM, 1'b0);

    // Offset sweep: the /I2/ stream delayed by d bits locks at offset d.
    for (int d = 0; d < 10; d++) begin
      do_reset();
      if (d > 0) q_push(20'h0, d);
      push_i2(12);
      for (int s = 0; s < 18; s++) begin
        step_q(1'b0);
        if (s == 4) check($sformatf("sweep%0d_not_yet_locked", d), 32'(rx_locked), 32'h0);
        if (s == 5) check($sformatf("sweep%0d_locked_c0p5", d),    32'(rx_locked), 32'h1);
        if (s == 13) check($sformatf("sweep%0d_offset", d),        32'(offset_mon), 32'(d));
        if (s >= 14) begin
          check($sformatf("sweep%0d_rxd_s%0d", d, s), 32'(rxd_out),
                32'((s % 2 == 1) ? K_SYM : D_SYM));
          check($sformatf("sweep%0d_comma_s%0d", d, s), 32'(comma_out), 32'(s % 2));
        end
      end
    end

    // Loss of lock: locked at offset 3, then 4 extra bits move it to 7.
    do_reset();
    q_push(20'h0, 3);
    push_i2(6);
    q_push(20'h5, 4);
    push_i2(8);
    for (int s = 0; s < 28; s++) begin
      step_q(1'b0);
      if (s == 5)  check("los_locked_at3",      32'(rx_locked),  32'h1);
      if (s == 17) check("los_3errs_still_lk",  32'(rx_locked),  32'h1);
      if (s == 17) check("los_offset_still3",   32'(offset_mon), 32'h3);
      if (s == 19) check("los_4errs_unlocked",  32'(rx_locked),  32'h0);
      if (s == 24) check("los_relock_pending",  32'(rx_locked),  32'h0);
      if (s == 25) check("los_relocked",        32'(rx_locked),  32'h1);
      if (s == 25) check("los_offset7",         32'(offset_mon), 32'h7);
      if (s == 26) check("los_rxd_even",        32'(rxd_out),    32'(D_SYM));
      if (s == 27) check("los_rxd_odd",         32'(rxd_out),    32'(K_SYM));
    end
`ifdef RX_ALIGN_STATS_EN
    check("los_lockloss_cnt", 32'(lockloss_cnt), 32'h1);
    check("los_realign_cnt",  32'(realign_cnt),  32'h2);
`endif

    // CHECK timeout: 64 comma-free cycles return to HUNT, 63 do not.
    for (int m = 63; m <= 64; m++) begin
      do_reset();
      locked_seen = 0;
      step(FILL, 1'b0);
      step(FILL, 1'b0);
      step(K_SYM, 1'b0);
      repeat (m) begin
        step(FILL, 1'b0);
        if (rx_locked) locked_seen++;
      end
      check($sformatf("timeout%0d_never_locked", m), 32'(locked_seen), 32'h0);
      for (int p = 1; p <= 3; p++) begin
        step(K_SYM, 1'b0);
        step(D_SYM, 1'b0);
        if (p == 2) check($sformatf("timeout%0d_pair2_locked", m), 32'(rx_locked),
                          32'((m == 63) ? 1 : 0));
        if (p == 3) check($sformatf("timeout%0d_pair3_locked", m), 32'(rx_locked), 32'h1);
      end
    end

    // Long frame: 10000 comma-free symbols while locked keep the lock.
    unlocked = 0;
    for (int i = 0; i < 10000; i++) begin
      step(FILL, 1'b0);
      if (!rx_locked) unlocked++;
    end
    check("long_frame_unlocked_cycles", 32'(unlocked),   32'h0);
    check("long_frame_rxd_out",         32'(rxd_out),    32'(FILL));
    check("long_frame_offset",          32'(offset_mon), 32'h0);

    // Reset while locked at offset 5 clears every output on the next edge.
    do_reset();
    q_push(20'h0, 5);
    push_i2(4);
    for (int s = 0; s < 7; s++) step_q(1'b0);
    check("rst_pre_locked", 32'(rx_locked),  32'h1);
    check("rst_pre_offset", 32'(offset_mon), 32'h5);
    rst = 1'b1;
    step_q(1'b0);
    check("rst_mid_rxd_out",   32'(rxd_out),    32'h0);
    check("rst_mid_comma_out", 32'(comma_out),  32'h0);
    check("rst_mid_locked",    32'(rx_locked),  32'h0);
    check("rst_mid_offset",    32'(offset_mon), 32'h0);
`ifdef RX_ALIGN_STATS_EN
    check("rst_mid_realign",   32'(realign_cnt),  32'h0);
    check("rst_mid_lockloss",  32'(lockloss_cnt), 32'h0);
`endif
    rst = 1'b0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
